// File: rtl/event_encoder8_3.sv
// event_encoder8_3: synchronises 8 asynchronous event lines, latches their rising edges
// as sticky pending bits and presents one binary code at a time on a valid/ready handshake.
module event_encoder8_3 #(
  parameter int SYNC_STAGES = 2,
  parameter bit LSB_FIRST   = 1'b1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] in_line,
  output logic [2:0] code_out,
  output logic       code_valid,
  input  logic       code_ready,
  output logic [7:0] pending,
  output logic       overflow,
  input  logic       ovf_clr
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t                      state, state_nxt;
  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0]                  sync_dly;
  logic [7:0]                  rise;
  logic [7:0]                  acc_mask;
  logic [7:0]                  pending_nxt;
  logic [2:0]                  code_nxt;
  logic                        accept;
  logic                        lost;

  // Last assignment wins, so the scan order decides which set bit has priority.
  function automatic logic [2:0] pick(input logic [7:0] v);
    pick = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (LSB_FIRST) begin
        if (v[7-i]) pick = 3'(7 - i);
      end else begin
        if (v[i]) pick = 3'(i);
      end
    end
  endfunction

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q   <= '0;
      sync_dly <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], in_line};
      sync_dly <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise        = sync_q[SYNC_STAGES-1] & ~sync_dly;
  assign accept      = code_valid & code_ready;
  assign acc_mask    = accept ? (8'd1 << code_out) : 8'd0;
  assign pending_nxt = (pending & ~acc_mask) | rise;
  // A rise on the bit being accepted in the same cycle simply re-arms it.
  assign lost        = |(rise & pending & ~acc_mask);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      overflow <= lost | (overflow & ~ovf_clr);
    end
  end

  always_comb begin
    state_nxt = state;
    code_nxt  = code_out;
    case (state)
      IDLE: begin
        if (pending != 8'd0) begin
          state_nxt = HOLD;
          code_nxt  = pick(pending);
        end
      end
      HOLD: begin
        if (code_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      code_out <= 3'd0;
    end else begin
      state    <= state_nxt;
      code_out <= code_nxt;
    end
  end

  assign code_valid = (state == HOLD);

endmodule

// File: tb/tb_event_encoder8_3.sv
// Bench for event_encoder8_3: one DUT per priority order, directed corner sequences,
// a vector table of simultaneous arrivals and a randomized run against a reference model.
module tb_event_encoder8_3;

  localparam int S = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [7:0] in_line;
  logic       code_ready;
  logic       ovf_clr;
  logic [2:0] code_a, code_b;
  logic       valid_a, valid_b;
  logic [7:0] pend_a, pend_b;
  logic       ovf_a, ovf_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] mask;
    int         first_a;
    int         first_b;
    int         count;
  } vec_t;

  vec_t vecs[7];
  int   seq_a[5];
  int   seq_b[5];

  // Reference state: raw input history plus per-DUT pending set, presented code and flag.
  logic [7:0] samp    [S+1];
  logic [7:0] m_pend  [2];
  logic [2:0] m_code  [2];
  logic       m_valid [2];
  logic       m_ovf   [2];

  always #5 sys_clk = ~sys_clk;

  event_encoder8_3 #(.SYNC_STAGES(S), .LSB_FIRST(1'b1)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_line(in_line),
    .code_out(code_a), .code_valid(valid_a), .code_ready(code_ready),
    .pending(pend_a), .overflow(ovf_a), .ovf_clr(ovf_clr)
  );

  event_encoder8_3 #(.SYNC_STAGES(S), .LSB_FIRST(1'b0)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_line(in_line),
    .code_out(code_b), .code_valid(valid_b), .code_ready(code_ready),
    .pending(pend_b), .overflow(ovf_b), .ovf_clr(ovf_clr)
  );

  function automatic int first_set(input logic [7:0] v, input bit lsb);
    first_set = -1;
    if (lsb) begin
      for (int i = 0; i < 8; i++) if (v[i] && first_set < 0) first_set = i;
    end else begin
      for (int i = 7; i >= 0; i--) if (v[i] && first_set < 0) first_set = i;
    end
  endfunction

  task automatic model_reset();
    for (int j = 0; j <= S; j++) samp[j] = 8'd0;
    for (int d = 0; d < 2; d++) begin
      m_pend[d]  = 8'd0;
      m_code[d]  = 3'd0;
      m_valid[d] = 1'b0;
      m_ovf[d]   = 1'b0;
    end
  endtask

  // A line counts as an event once its 0->1 step has travelled through the synchroniser.
  task automatic model_step();
    logic [7:0] ev;
    logic [7:0] old_pend;
    int         taken;
    int         best;
    bit         any_lost;
    ev = samp[S-1] & ~samp[S];
    for (int j = S; j > 0; j--) samp[j] = samp[j-1];
    samp[0] = in_line;
    for (int d = 0; d < 2; d++) begin
      old_pend = m_pend[d];
      taken    = (m_valid[d] && code_ready) ? int'(m_code[d]) : -1;
      any_lost = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (ev[i] && old_pend[i] && i != taken) any_lost = 1'b1;
        m_pend[d][i] = (old_pend[i] && i != taken) || ev[i];
      end
      m_ovf[d] = any_lost || (m_ovf[d] && !ovf_clr);
      if (m_valid[d]) begin
        if (code_ready) m_valid[d] = 1'b0;
      end else begin
        best = first_set(old_pend, d == 0);
        if (best >= 0) begin
          m_code[d]  = 3'(best);
          m_valid[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    if (!sys_rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check_output({tag, "_lsb"}, {valid_a, code_a, pend_a, ovf_a},
                 {m_valid[0], m_code[0], m_pend[0], m_ovf[0]});
    check_output({tag, "_msb"}, {valid_b, code_b, pend_b, ovf_b},
                 {m_valid[1], m_code[1], m_pend[1], m_ovf[1]});
  endtask

  task automatic wait_valid(input string name, input int bound);
    int n;
    n = 0;
    while (!valid_a && n < bound) begin
      tick();
      n++;
    end
    check_output({name, "_wait"}, valid_a, 1'b1);
  endtask

  task automatic apply_stimulus(input logic [7:0] mask, input int high_cycles);
    in_line = mask;
    repeat (high_cycles) tick();
    in_line = 8'd0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int na, nb, fa, fb;

    vecs[0] = '{8'h80, 7, 7, 1};
    vecs[1] = '{8'h01, 0, 0, 1};
    vecs[2] = '{8'h24, 2, 5, 2};
    vecs[3] = '{8'h94, 2, 7, 3};
    vecs[4] = '{8'h60, 5, 6, 2};
    vecs[5] = '{8'hFF, 0, 7, 8};
    vecs[6] = '{8'h0A, 1, 3, 2};
    seq_a   = '{2, 0, 4, 0, 7};
    seq_b   = '{7, 0, 4, 0, 2};

    sys_rst_n  = 1'b0;
    in_line    = 8'd0;
    code_ready = 1'b0;
    ovf_clr    = 1'b0;
    model_reset();
    repeat (3) tick();

    // Quiet after reset release
    sys_rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_output("reset_idle", {valid_a, code_a, pend_a, ovf_a, valid_b, code_b, pend_b, ovf_b}, 32'd0);
    end

    // Single event latency on line 5
    code_ready = 1'b1;
    in_line    = 8'h20;
    tick();
    tick();
    tick();
    check_output("lat_early", valid_a, 1'b0);
    check_output("lat_pending", pend_a, 8'h20);
    in_line = 8'd0;
    tick();
    check_output("lat_code_a", {valid_a, code_a}, {1'b1, 3'd5});
    check_output("lat_code_b", {valid_b, code_b}, {1'b1, 3'd5});
    tick();
    check_output("lat_done", {valid_a, pend_a}, 9'd0);
    repeat (6) tick();

    // Lines 7, 2, 4 together: order and one idle cycle between codes
    in_line = 8'h94;
    tick();
    tick();
    tick();
    in_line = 8'd0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_output("order_valid_a", valid_a, (k % 2 == 0));
      check_output("order_valid_b", valid_b, (k % 2 == 0));
      if (k % 2 == 0) begin
        check_output("order_code_a", code_a, seq_a[k]);
        check_output("order_code_b", code_b, seq_b[k]);
      end
    end
    repeat (6) tick();

    // Vector table of simultaneous arrivals
    for (int r = 0; r < 7; r++) begin
      na = 0; nb = 0; fa = -1; fb = -1;
      code_ready = 1'b1;
      in_line    = vecs[r].mask;
      for (int t = 0; t < 34; t++) begin
        tick();
        if (t == 2) in_line = 8'd0;
        if (valid_a) begin
          if (na == 0) fa = int'(code_a);
          na++;
        end
        if (valid_b) begin
          if (nb == 0) fb = int'(code_b);
          nb++;
        end
      end
      check_output("vec_first_a", fa, vecs[r].first_a);
      check_output("vec_first_b", fb, vecs[r].first_b);
      check_output("vec_count_a", na, vecs[r].count);
      check_output("vec_count_b", nb, vecs[r].count);
    end

    // Presented code is not pre-empted by a higher-priority arrival
    code_ready = 1'b0;
    apply_stimulus(8'h08, 3);
    wait_valid("hold3", 10);
    check_output("hold_code", code_a, 3'd3);
    apply_stimulus(8'h01, 3);
    repeat (4) begin
      tick();
      check_output("hold_stable", {valid_a, code_a, valid_b, code_b}, {1'b1, 3'd3, 1'b1, 3'd3});
    end
    check_output("hold_pending", pend_a, 8'h09);
    code_ready = 1'b1;
    tick();
    check_output("hold_release", valid_a, 1'b0);
    tick();
    check_output("hold_next", {valid_a, code_a, valid_b, code_b}, {1'b1, 3'd0, 1'b1, 3'd0});
    repeat (4) tick();

    // Overflow: set, sticky, clear, and set winning over clear
    code_ready = 1'b0;
    apply_stimulus(8'h40, 3);
    repeat (3) tick();
    check_output("ovf_present", {valid_a, code_a}, {1'b1, 3'd6});
    check_output("ovf_none", {ovf_a, ovf_b}, 2'b00);
    apply_stimulus(8'h40, 3);
    repeat (2) tick();
    check_output("ovf_set", {ovf_a, ovf_b}, 2'b11);
    repeat (5) tick();
    check_output("ovf_sticky", {ovf_a, ovf_b}, 2'b11);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_output("ovf_clear", {ovf_a, ovf_b}, 2'b00);
    in_line = 8'h40;
    tick();
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    in_line = 8'd0;
    check_output("ovf_set_wins", {ovf_a, ovf_b}, 2'b11);
    code_ready = 1'b1;
    repeat (4) tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tick();
    check_output("ovf_drained", {pend_a, ovf_a, pend_b, ovf_b}, 18'd0);

    // Asynchronous reset mid-HOLD, then a line held high through release
    code_ready = 1'b0;
    apply_stimulus(8'h0A, 3);
    wait_valid("rst_hold", 10);
    check_output("rst_pre", {code_a, pend_a}, {3'd1, 8'h0A});
    in_line = 8'h02;
    #2;
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    check_output("rst_async", {valid_a, code_a, pend_a, ovf_a, valid_b, code_b, pend_b, ovf_b}, 32'd0);
    tick();
    #2;
    sys_rst_n  = 1'b1;
    code_ready = 1'b1;
    na = 0; nb = 0; fa = -1; fb = -1;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (valid_a) begin
        na++;
        fa = int'(code_a);
      end
      if (valid_b) begin
        nb++;
        fb = int'(code_b);
      end
    end
    check_output("rst_one_count_a", na, 1);
    check_output("rst_one_count_b", nb, 1);
    check_output("rst_one_code", {fa[2:0], fb[2:0]}, {3'd1, 3'd1});
    in_line = 8'd0;
    repeat (5) tick();

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 8; i++) if ($urandom_range(0, 5) == 0) in_line[i] = ~in_line[i];
      code_ready = ($urandom_range(0, 3) != 0);
      ovf_clr    = ($urandom_range(0, 15) == 0);
      tick();
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
